// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_WAIT = 2'b01,
    DMEM_RESP = 2'b10
  } dmem_state_t;

  // size stays a raw 2-bit field so the illegal encoding 2'b11 can be latched and flagged
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      size;
    logic            is_unsigned;
  } dmem_req_t;

  function automatic logic [NBYTES-1:0] byte_enables(logic [1:0] size, logic [1:0] off);
    logic [NBYTES-1:0] be;
    be = '0;
    case (size)
      MEM_BYTE: be = 4'b0001 << off;
      MEM_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: be = 4'b1111;
      default:  be = '0;
    endcase
    return be;
  endfunction

  function automatic logic access_error(logic [XLEN-1:0] addr, logic [1:0] size,
                                        int unsigned depth_words);
    logic bad;
    bad = 1'b0;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = addr[0];
      MEM_WORD: bad = |addr[1:0];
      default:  bad = 1'b1;
    endcase
    if (XLEN'(addr[XLEN-1:2]) >= depth_words) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channel between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder_load_align.sv
// Lane select plus sign/zero extension of a loaded word; purely combinational.
module dmem_responder_load_align
  import dmem_responder_pkg::*;
(
  input  logic [XLEN-1:0] rword,
  input  logic [1:0]      off,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] rdata_c
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b   = rword[{off, 3'b000} +: 8];
    sel_h   = off[1] ? rword[31:16] : rword[15:0];
    rdata_c = '0;
    case (size)
      MEM_BYTE: rdata_c = is_unsigned ? XLEN'(sel_b) : {{(XLEN-8){sel_b[7]}}, sel_b};
      MEM_HALF: rdata_c = is_unsigned ? XLEN'(sel_h) : {{(XLEN-16){sel_h[15]}}, sel_h};
      MEM_WORD: rdata_c = rword;
      default:  rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency and byte-lane stores.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  dmem_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  dmem_req_t         req_q, req_in_c, acc_c;
  logic              req_ready_q, rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic              accept_c, commit_c, err_c;
  logic [IDX_W-1:0]  idx_c;
  logic [NBYTES-1:0] be_c;
  logic [XLEN-1:0]   wrep_c, load_c;
  logic [XLEN-1:0]   mem [DEPTH_WORDS];

  always_comb begin
    req_in_c = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata,
                 size: bus.req_size, is_unsigned: bus.req_unsigned};
  end

  // With single-cycle latency the access happens on the accept edge, so use the live request
  always_comb begin
    acc_c = req_q;
    if (LATENCY == 1 && state_q == DMEM_IDLE) acc_c = req_in_c;
  end

  always_comb begin
    err_c = access_error(acc_c.addr, acc_c.size, DEPTH_WORDS);
    idx_c = acc_c.addr[IDX_W+1:2];
    be_c  = byte_enables(acc_c.size, acc_c.addr[1:0]);
    case (acc_c.size)
      MEM_BYTE: wrep_c = {4{acc_c.wdata[7:0]}};
      MEM_HALF: wrep_c = {2{acc_c.wdata[15:0]}};
      default:  wrep_c = acc_c.wdata;
    endcase
  end

  dmem_responder_load_align u_align (
    .rword       (mem[idx_c]),
    .off         (acc_c.addr[1:0]),
    .size        (acc_c.size),
    .is_unsigned (acc_c.is_unsigned),
    .rdata_c     (load_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (bus.req_valid) begin
          accept_c = 1'b1;
          if (LATENCY == 1) begin
            state_d  = DMEM_RESP;
            commit_c = 1'b1;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = CNT_W'(LATENCY - 2);
          end
        end
      end
      DMEM_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = DMEM_RESP;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DMEM_RESP: begin
        if (bus.rsp_ready) state_d = DMEM_IDLE;
      end
      default: state_d = DMEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= DMEM_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= (state_d == DMEM_IDLE);
      rsp_valid_q <= (state_d == DMEM_RESP);
      if (accept_c) req_q <= req_in_c;
      if (commit_c) begin
        rsp_err_q   <= err_c;
        rsp_rdata_q <= (err_c || acc_c.we) ? '0 : load_c;
      end
    end
  end

  // Storage is deliberately not reset; a reset before commit leaves commit_c low
  always_ff @(posedge clk) begin
    if (commit_c && acc_c.we && !err_c) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (be_c[i]) mem[idx_c][8*i +: 8] <= wrep_c[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-addressed reference memory plus cycle-stamped response model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int unsigned L     = 2;
  localparam int unsigned DEPTH = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string what);
    n_checks++;
    n_err++;
    $display("FAIL timeout_%s: no DUT response within bound at %0t", what, $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  endtask

  // Reference model: memory is a sparse byte map; a transaction is described by its accept cycle
  bit [7:0]    mem_m [int unsigned];
  bit          busy, resp_out;
  longint      cyc, acc_cyc;
  logic        m_we, m_uns;
  logic [31:0] m_addr, m_wdata;
  logic [1:0]  m_size;
  logic [31:0] exp_rdata;
  bit          exp_err, exp_known;

  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] s);
    int unsigned n;
    if (s == 2'b11) return 1'b1;
    n = 1 << s;
    if ((a % n) != 0) return 1'b1;
    return (a / 4) >= DEPTH;
  endfunction

  task automatic model_commit();
    int unsigned n;
    logic [31:0] v;
    exp_err   = ref_err(m_addr, m_size);
    exp_rdata = 32'h0;
    exp_known = 1'b1;
    if (exp_err) return;
    n = 1 << m_size;
    if (m_we) begin
      for (int i = 0; i < int'(n); i++) mem_m[int'(m_addr) + i] = m_wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < int'(n); i++) begin
        if (mem_m.exists(int'(m_addr) + i)) v[8*i +: 8] = mem_m[int'(m_addr) + i];
        else exp_known = 1'b0;
      end
      if (!m_uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      exp_rdata = v;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     = 1'b0;
      resp_out = 1'b0;
    end else begin
      cyc++;
      if (resp_out) begin
        if (bus.rsp_ready) begin
          busy     = 1'b0;
          resp_out = 1'b0;
        end
      end else if (!busy && bus.req_valid) begin
        busy    = 1'b1;
        acc_cyc = cyc;
        m_we    = bus.req_we;
        m_addr  = bus.req_addr;
        m_wdata = bus.req_wdata;
        m_size  = bus.req_size;
        m_uns   = bus.req_unsigned;
      end
      if (busy && !resp_out && cyc == acc_cyc + L - 1) begin
        model_commit();
        resp_out = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check_b("rst_req_ready", bus.req_ready, 1'b1);
      check_b("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check_w("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check_b("rst_rsp_err",   bus.rsp_err,   1'b0);
    end else begin
      check_b("req_ready", bus.req_ready, !busy);
      check_b("rsp_valid", bus.rsp_valid, resp_out);
      if (resp_out) begin
        check_b("rsp_err", bus.rsp_err, exp_err);
        if (exp_known) check_w("rsp_rdata", bus.rsp_rdata, exp_rdata);
      end
    end
  end

  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input int bp, input bit noise,
                        output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_size = size; bus.req_unsigned = uns;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (guard > 50) timeout_fail("accept");
    end while (!bus.req_ready);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid) break;
      if (lat > 50) timeout_fail("response");
      @(posedge clk); #1;
      if (noise) begin
        bus.rsp_ready = 1'($urandom_range(0, 1));
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom_range(0, 63);
        bus.req_wdata = $urandom;
      end
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    if (!bus.rsp_ready) begin
      for (int i = 0; i < bp; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check_b("hold_rsp_valid", bus.rsp_valid, 1'b1);
        check_b("hold_req_ready", bus.req_ready, 1'b0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  logic [31:0] rd, a;
  logic        er;
  int          lat;
  logic [1:0]  sz;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b0; bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_b("init_req_ready", bus.req_ready, 1'b1);
    check_b("init_rsp_valid", bus.rsp_valid, 1'b0);
    check_w("init_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_b("init_rsp_err",   bus.rsp_err,   1'b0);

    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    check_w("st_word_lat", 32'(lat), 32'd2);
    check_b("st_word_err", er, 1'b0);
    check_w("st_word_rdata", rd, 32'h0);
    do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    check_w("ld_word_lat", 32'(lat), 32'd2);
    check_w("ld_word", rd, 32'hDEADBEEF);
    check_b("ld_word_err", er, 1'b0);

    do_txn(1'b1, 32'h11, 32'h80, 2'b00, 1'b0, 0, 1'b0, rd, er, lat);
    do_txn(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 0, 1'b0, rd, er, lat);
    check_w("ld_byte_signed", rd, 32'hFFFFFF80);
    do_txn(1'b0, 32'h11, 32'h0, 2'b00, 1'b1, 0, 1'b0, rd, er, lat);
    check_w("ld_byte_unsigned", rd, 32'h00000080);
    do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    check_w("ld_word_merged", rd, 32'hDEAD80EF);
    do_txn(1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 0, 1'b0, rd, er, lat);
    check_w("ld_half_signed", rd, 32'hFFFFDEAD);

    do_txn(1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 0, 1'b0, rd, er, lat);
    check_b("ld_half_misalign_err", er, 1'b1);
    check_w("ld_half_misalign_rdata", rd, 32'h0);
    do_txn(1'b1, 32'h12, 32'hCAFEF00D, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    check_b("st_word_misalign_err", er, 1'b1);
    check_w("st_word_misalign_rdata", rd, 32'h0);
    do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    check_w("ld_word_after_err", rd, 32'hDEAD80EF);
    do_txn(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, 1'b0, rd, er, lat);
    check_b("illegal_size_err", er, 1'b1);
    do_txn(1'b0, 32'h1000, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    check_b("out_of_range_err", er, 1'b1);
    do_txn(1'b1, 32'hFFC, 32'h5A5AA5A5, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    do_txn(1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    check_w("last_word", rd, 32'h5A5AA5A5);
    check_b("last_word_err", er, 1'b0);

    do_txn(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, 1'b0, rd, er, lat);
    check_w("bp_rdata", rd, 32'hDEAD80EF);
    @(negedge clk);
    check_b("bp_ready_after", bus.req_ready, 1'b1);

    // Reset lands in the wait phase of a store, so the store must never reach memory
    do_txn(1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20;
    bus.req_wdata = 32'h12345678; bus.req_size = 2'b10;
    @(negedge clk);
    check_b("mid_accept_ready", bus.req_ready, 1'b1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_b("mid_wait_ready", bus.req_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    check_b("mid_rst_req_ready", bus.req_ready, 1'b1);
    check_b("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_b("post_rst_req_ready", bus.req_ready, 1'b1);
    check_b("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
    do_txn(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, 1'b0, rd, er, lat);
    check_w("post_rst_ld", rd, 32'h11223344);

    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h1000 + $urandom_range(0, 15);
        1:       a = $urandom;
        2:       a = 32'hFFC + $urandom_range(0, 3);
        default: a = $urandom_range(0, 63);
      endcase
      sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_txn(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'b1, rd, er, lat);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
